// File: rtl/mcu_scheduler.sv
// MCU row scheduler: steps one-hot encoder requests Y -> Cb -> Cr -> gap for each MCU
// of a row, with deferred launch under hold, abort cancellation and a sticky overrun flag.
module mcu_scheduler #(
  parameter int SLOT_Y = 29,
  parameter int SLOT_C = 7,
  parameter int GAP    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] h_mcu,
  input  logic       hold,
  input  logic       abort,
  output logic [2:0] ereq,
  output logic [7:0] e_x_mcu,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_Y    = 3'd1,
    S_CB   = 3'd2,
    S_CR   = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [5:0] LP_Y_LAST   = 6'(SLOT_Y - 1);
  localparam logic [5:0] LP_C_LAST   = 6'(SLOT_C - 1);
  localparam logic [5:0] LP_GAP_LAST = 6'(GAP - 1);

  state_t     r_state, w_state_nxt;
  logic [5:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_len, w_len_nxt;
  logic [7:0] r_x, w_x_nxt;
  logic [7:0] w_row_len;
  logic [2:0] r_ereq, w_ereq_nxt;
  logic       r_pend, w_pend_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_err, w_err_nxt;
  logic       w_start_ok;

  assign ereq    = r_ereq;
  assign e_x_mcu = r_x;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err;

  // Next-state, slot counter and next values of every registered output
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 6'd1;
    w_len_nxt   = r_len;
    w_x_nxt     = r_x;
    w_pend_nxt  = r_pend;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_ereq_nxt  = 3'b000;
    w_start_ok  = start && (r_state == S_IDLE) && !r_pend;
    // A freshly accepted start launches with the live h_mcu, a pending one with the latched length
    w_row_len   = w_start_ok ? h_mcu : r_len;

    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 6'd0;
      w_x_nxt     = 8'd0;
      w_pend_nxt  = 1'b0;
    end else begin
      if (start && !w_start_ok) begin
        w_err_nxt = 1'b1;
      end else begin
        w_err_nxt = r_err;
      end
      if (w_start_ok) begin
        w_len_nxt = h_mcu;
      end else begin
        w_len_nxt = r_len;
      end

      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = 6'd0;
          if ((w_start_ok || r_pend) && hold) begin
            w_pend_nxt = 1'b1;
          end else if (w_start_ok || r_pend) begin
            w_pend_nxt = 1'b0;
            if (w_row_len == 8'd0) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = S_Y;
            end
          end else begin
            w_pend_nxt = r_pend;
          end
        end
        S_Y: begin
          if (r_cnt == LP_Y_LAST) begin
            w_state_nxt = S_CB;
            w_cnt_nxt   = 6'd0;
          end else begin
            w_state_nxt = S_Y;
          end
        end
        S_CB: begin
          if (r_cnt == LP_C_LAST) begin
            w_state_nxt = S_CR;
            w_cnt_nxt   = 6'd0;
          end else begin
            w_state_nxt = S_CB;
          end
        end
        S_CR: begin
          if (r_cnt == LP_C_LAST) begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = 6'd0;
          end else begin
            w_state_nxt = S_CR;
          end
        end
        S_GAP: begin
          if (r_cnt == LP_GAP_LAST) begin
            w_cnt_nxt = 6'd0;
            if (({1'b0, r_x} + 9'd1) < {1'b0, r_len}) begin
              w_x_nxt     = r_x + 8'd1;
              w_state_nxt = S_Y;
            end else begin
              w_x_nxt     = 8'd0;
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = S_GAP;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 6'd0;
          w_x_nxt     = 8'd0;
          w_pend_nxt  = 1'b0;
        end
      endcase
    end

    case (w_state_nxt)
      S_Y:     w_ereq_nxt = 3'b001;
      S_CB:    w_ereq_nxt = 3'b010;
      S_CR:    w_ereq_nxt = 3'b100;
      default: w_ereq_nxt = 3'b000;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE) || w_pend_nxt;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_len   <= 8'd0;
      r_x     <= 8'd0;
      r_ereq  <= 3'b000;
      r_pend  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_x     <= w_x_nxt;
      r_ereq  <= w_ereq_nxt;
      r_pend  <= w_pend_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_mcu_scheduler.sv
// Bench for mcu_scheduler: directed scenarios plus random traffic, all checked against a
// cycle-arithmetic model (row launch cycle, row length, MCU period).
module tb_mcu_scheduler;

  localparam int Y   = 29;
  localparam int C   = 7;
  localparam int G   = 8;
  localparam int PER = Y + 2 * C + G;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] h_mcu;
  logic       hold;
  logic       abort;
  logic [2:0] ereq;
  logic [7:0] e_x_mcu;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Model: a launched row owns cycles [m_first, m_end); done is expected at cycle m_done.
  bit m_act, m_pend, m_err;
  int m_first, m_end, m_done, m_plen;

  always #5 clk = ~clk;

  mcu_scheduler #(.SLOT_Y(Y), .SLOT_C(C), .GAP(G)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .h_mcu(h_mcu), .hold(hold), .abort(abort),
    .ereq(ereq), .e_x_mcu(e_x_mcu), .busy(busy), .done(done), .err(err)
  );

  function automatic bit in_row(input int k);
    return m_act && (k >= m_first) && (k < m_end);
  endfunction

  function automatic logic [2:0] exp_ereq(input int k);
    int ph;
    if (!in_row(k)) return 3'b000;
    ph = (k - m_first) % PER;
    if (ph < Y) return 3'b001;
    if (ph < Y + C) return 3'b010;
    if (ph < Y + 2 * C) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic [7:0] exp_ex(input int k);
    if (!in_row(k)) return 8'd0;
    return 8'((k - m_first) / PER);
  endfunction

  function automatic void model_reset();
    m_act = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    m_first = 0; m_end = 0; m_done = -1; m_plen = 0;
  endfunction

  function automatic void launch(input int n, input int len);
    if (len == 0) begin
      m_act  = 1'b0;
      m_done = n + 1;
    end else begin
      m_act   = 1'b1;
      m_first = n + 1;
      m_end   = m_first + len * PER;
      m_done  = m_end;
    end
  endfunction

  // Inputs sampled at the edge closing cycle n decide the outputs of cycle n+1.
  function automatic void model_edge(input int n, input bit s, input bit hd, input bit ab,
                                     input logic [7:0] h);
    bit idle_n, acc;
    idle_n = !in_row(n);
    if (ab) begin
      m_act  = 1'b0;
      m_pend = 1'b0;
      m_done = -1;
    end else begin
      acc = s && idle_n && !m_pend;
      if (s && !acc) m_err = 1'b1;
      if (acc) m_plen = int'(h);
      if (acc || m_pend) begin
        if (hd) begin
          m_pend = 1'b1;
        end else begin
          m_pend = 1'b0;
          launch(n, m_plen);
        end
      end
    end
  endfunction

  task automatic tick(input bit s, input bit hd, input bit ab, input logic [7:0] h);
    start = s; hold = hd; abort = ab; h_mcu = h;
    @(posedge clk);
    model_edge(cyc, s, hd, ab, h);
    cyc++;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy === 1'b1; i++) tick(1'b0, 1'b0, 1'b0, 8'd0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle timeout busy=%b required=0", busy);
    end
  endtask

  // Continuous comparison of every output against the model, plus one-hot-or-zero on ereq
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (ereq !== exp_ereq(cyc)) begin
        errors++; $display("FAIL mon_ereq cyc=%0d got=%b exp=%b", cyc, ereq, exp_ereq(cyc));
      end
      checks++;
      if (e_x_mcu !== exp_ex(cyc)) begin
        errors++; $display("FAIL mon_ex cyc=%0d got=%0d exp=%0d", cyc, e_x_mcu, exp_ex(cyc));
      end
      checks++;
      if (busy !== (in_row(cyc) || m_pend)) begin
        errors++; $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, in_row(cyc) || m_pend);
      end
      checks++;
      if (done !== (cyc == m_done)) begin
        errors++; $display("FAIL mon_done cyc=%0d got=%b exp=%b", cyc, done, cyc == m_done);
      end
      checks++;
      if (err !== m_err) begin
        errors++; $display("FAIL mon_err cyc=%0d got=%b exp=%b", cyc, err, m_err);
      end
      checks++;
      if ((ereq & (ereq - 3'd1)) !== 3'b000) begin
        errors++; $display("FAIL onehot cyc=%0d got=%b required=one-hot-or-zero", cyc, ereq);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0; h_mcu = 8'd0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ereq, e_x_mcu, busy, done, err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h required=0", {ereq, e_x_mcu, busy, done, err});
    end
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_row3();
    logic [2:0] e;
    tick(1'b1, 1'b0, 1'b0, 8'd3);
    for (int k = 1; k <= 160; k++) begin
      if (k <= 51) begin
        e = (k <= 29) ? 3'b001 : (k <= 36) ? 3'b010 : (k <= 43) ? 3'b100 : 3'b000;
        checks++;
        if (ereq !== e) begin
          errors++; $display("FAIL row3_ereq k=%0d got=%b required=%b", k, ereq, e);
        end
      end
      if (k == 1 || k == 52 || k == 103) begin
        checks++;
        if (e_x_mcu !== 8'((k - 1) / 51) || ereq !== 3'b001) begin
          errors++; $display("FAIL row3_mcu k=%0d ex=%0d ereq=%b required ex=%0d ereq=001",
                             k, e_x_mcu, ereq, (k - 1) / 51);
        end
      end
      checks++;
      if (done !== (k == 154)) begin
        errors++; $display("FAIL row3_done k=%0d got=%b required=%b", k, done, k == 154);
      end
      tick(1'b0, 1'b0, 1'b0, 8'd0);
    end
  endtask

  task automatic test_hold();
    tick(1'b1, 1'b1, 1'b0, 8'd2);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (busy !== 1'b1 || ereq !== 3'b000) begin
        errors++; $display("FAIL hold_wait i=%0d busy=%b ereq=%b required busy=1 ereq=000", i, busy, ereq);
      end
      if (i < 9) tick(1'b0, 1'b1, 1'b0, 8'd0);
    end
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    checks++;
    if (ereq !== 3'b001 || e_x_mcu !== 8'd0) begin
      errors++; $display("FAIL hold_launch ereq=%b ex=%0d required ereq=001 ex=0", ereq, e_x_mcu);
    end
    tick(1'b0, 1'b1, 1'b0, 8'd0);
    checks++;
    if (ereq !== 3'b001) begin
      errors++; $display("FAIL hold_ignored ereq=%b required=001", ereq);
    end
    wait_idle(3 * PER);
  endtask

  task automatic test_empty();
    tick(1'b1, 1'b0, 1'b0, 8'd0);
    checks++;
    if (done !== 1'b1 || ereq !== 3'b000 || busy !== 1'b0) begin
      errors++; $display("FAIL empty_row done=%b ereq=%b busy=%b required 1/000/0", done, ereq, busy);
    end
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL empty_pulse done=%b required=0", done);
    end
  endtask

  task automatic test_abort();
    tick(1'b1, 1'b0, 1'b0, 8'd4);
    repeat (133) tick(1'b0, 1'b0, 1'b0, 8'd0);
    checks++;
    if (ereq !== 3'b010 || e_x_mcu !== 8'd2) begin
      errors++; $display("FAIL abort_setup ereq=%b ex=%0d required 010/2", ereq, e_x_mcu);
    end
    tick(1'b0, 1'b0, 1'b1, 8'd0);
    checks++;
    if ({ereq, e_x_mcu, busy, done, err} !== 14'd0) begin
      errors++; $display("FAIL abort_cb got=%h required=0", {ereq, e_x_mcu, busy, done, err});
    end
    repeat (5) tick(1'b0, 1'b0, 1'b0, 8'd0);
    tick(1'b1, 1'b0, 1'b1, 8'd5);
    checks++;
    if ({ereq, busy, done, err} !== 6'd0) begin
      errors++; $display("FAIL abort_start got=%b required=0", {ereq, busy, done, err});
    end
    tick(1'b0, 1'b0, 1'b0, 8'd0);
    checks++;
    if (ereq !== 3'b000) begin
      errors++; $display("FAIL abort_discard ereq=%b required=000", ereq);
    end
  endtask

  task automatic test_overrun();
    int max_ex = 0;
    int dcount = 0;
    tick(1'b1, 1'b0, 1'b0, 8'd4);
    repeat (59) tick(1'b0, 1'b0, 1'b0, 8'd0);
    tick(1'b1, 1'b0, 1'b0, 8'd9);
    checks++;
    if (err !== 1'b1 || e_x_mcu !== 8'd1) begin
      errors++; $display("FAIL overrun_err err=%b ex=%0d required 1/1", err, e_x_mcu);
    end
    for (int i = 0; i < 250; i++) begin
      tick(1'b0, 1'b0, 1'b0, 8'd0);
      if (done === 1'b1) dcount++;
      if (int'(e_x_mcu) > max_ex) max_ex = int'(e_x_mcu);
    end
    checks++;
    if (max_ex != 3 || dcount != 1 || err !== 1'b1) begin
      errors++; $display("FAIL overrun_row max_ex=%0d dones=%0d err=%b required 3/1/1", max_ex, dcount, err);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b0, 1'b0, 8'd2);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 8'd0);
    checks++;
    if (ereq !== 3'b001) begin
      errors++; $display("FAIL areset_setup ereq=%b required=001", ereq);
    end
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ereq, e_x_mcu, busy, done, err} !== 14'd0) begin
      errors++; $display("FAIL areset_outputs got=%h required=0", {ereq, e_x_mcu, busy, done, err});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL areset_done done=%b required=0", done);
    end
    model_reset();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 8'd1);
    checks++;
    if (ereq !== 3'b001 || busy !== 1'b1) begin
      errors++; $display("FAIL areset_first_start ereq=%b busy=%b required 001/1", ereq, busy);
    end
    wait_idle(2 * PER);
  endtask

  task automatic test_random();
    bit hd = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) hd = ~hd;
      tick($urandom_range(0, 39) == 0, hd, $urandom_range(0, 299) == 0,
           8'($urandom_range(0, 4)));
    end
    wait_idle(6 * PER);
  endtask

  initial begin
    test_reset();
    test_row3();
    test_hold();
    test_empty();
    test_abort();
    test_overrun();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
